// File: rtl/core_refill_arbiter.sv
// rtl/core_refill_arbiter.sv - arbiter sharing one refill/uncached bus between fetch (I) and dcache (D)
module core_refill_arbiter #(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [7:0]  i_req_len,
  input  logic        i_clr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [7:0]  d_req_len,
  input  logic        d_req_write,
  input  logic        d_wvalid,
  output logic        d_wready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        m_avalid,
  input  logic        m_aready,
  output logic [31:0] m_aaddr,
  output logic [7:0]  m_alen,
  output logic        m_awrite,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_bvalid,
  output logic        bus_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_RDATA = 3'd2,
    S_WDATA = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_is_d_q, owner_is_d_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic        drop_q, drop_d;
  logic [7:0]  starve_q, starve_d;

  logic i_eff, i_grant, d_grant;
  logic rd_i, rd_d, wr_phase;

  // Grants are suppressed while rst is held so the reset cycle shows all-zero outputs.
  always_comb begin
    i_eff   = i_req_valid & ~i_clr;
    i_grant = (state_q == S_IDLE) & ~rst & i_eff & (~d_req_valid | (starve_q == LIMIT));
    d_grant = (state_q == S_IDLE) & ~rst & ~i_grant & d_req_valid;
  end

  always_comb begin
    rd_i     = (state_q == S_RDATA) & ~owner_is_d_q;
    rd_d     = (state_q == S_RDATA) & owner_is_d_q;
    wr_phase = (state_q == S_WDATA);

    i_req_ready = i_grant;
    d_req_ready = d_grant;

    m_avalid = (state_q == S_ADDR);
    m_aaddr  = addr_q;
    m_alen   = len_q;
    m_awrite = write_q;

    i_rvalid = rd_i & ~drop_q & m_rvalid;
    i_rlast  = i_rvalid & m_rlast;
    i_rdata  = rd_i ? m_rdata : 32'd0;
    d_rvalid = rd_d & m_rvalid;
    d_rlast  = d_rvalid & m_rlast;
    d_rdata  = rd_d ? m_rdata : 32'd0;

    m_wvalid = wr_phase & d_wvalid;
    d_wready = wr_phase & m_wready;
    m_wdata  = wr_phase ? d_wdata : 32'd0;
    m_wstrb  = wr_phase ? d_wstrb : 4'd0;
    m_wlast  = wr_phase & d_wlast;

    bus_busy_o = (state_q != S_IDLE);
  end

  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    write_d      = write_q;
    addr_d       = addr_q;
    len_d        = len_q;
    case (state_q)
      S_IDLE: begin
        if (i_grant) begin
          owner_is_d_d = 1'b0;
          write_d      = 1'b0;
          addr_d       = i_req_addr;
          len_d        = i_req_len;
          state_d      = S_ADDR;
        end else if (d_grant) begin
          owner_is_d_d = 1'b1;
          write_d      = d_req_write;
          addr_d       = d_req_addr;
          len_d        = d_req_len;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_aready) state_d = write_q ? S_WDATA : S_RDATA;
      end
      S_RDATA: begin
        if (m_rvalid & m_rlast) state_d = S_IDLE;
      end
      S_WDATA: begin
        if (m_wvalid & m_wready & m_wlast) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (m_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A cancelled I read still runs to m_rlast on the bus; only delivery to the frontend stops.
  always_comb begin
    drop_d = drop_q | (i_clr & ~owner_is_d_q & ((state_q == S_ADDR) | (state_q == S_RDATA)));
    if (state_d == S_IDLE) drop_d = 1'b0;

    if (i_grant | i_clr | ~i_req_valid) begin
      starve_d = 8'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_is_d_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      len_q        <= 8'd0;
      drop_q       <= 1'b0;
      starve_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      drop_q       <= drop_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_core_refill_arbiter.sv
// tb/tb_core_refill_arbiter.sv - self-checking bench for core_refill_arbiter with a transaction-level model
module tb_core_refill_arbiter;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_req_valid, i_req_ready, i_clr, i_rvalid, i_rlast;
  logic [31:0] i_req_addr, i_rdata;
  logic [7:0]  i_req_len;
  logic d_req_valid, d_req_ready, d_req_write, d_wvalid, d_wready, d_wlast, d_rvalid, d_rlast;
  logic [31:0] d_req_addr, d_wdata, d_rdata;
  logic [7:0]  d_req_len;
  logic [3:0]  d_wstrb;
  logic m_avalid, m_aready, m_awrite, m_wvalid, m_wready, m_wlast, m_rvalid, m_rlast, m_bvalid;
  logic [31:0] m_aaddr, m_wdata, m_rdata;
  logic [7:0]  m_alen;
  logic [3:0]  m_wstrb;
  logic bus_busy_o;

  int checks = 0;
  int errors = 0;

  core_refill_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_req_len(i_req_len), .i_clr(i_clr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_len(d_req_len), .d_req_write(d_req_write),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_awrite(m_awrite),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_bvalid(m_bvalid),
    .bus_busy_o(bus_busy_o)
  );

  always #5 clk = ~clk;

  // Model: one transaction descriptor with progress flags instead of a state register.
  logic        t_active, t_own_d, t_write, t_adone, t_ddone, t_drop;
  logic [31:0] t_addr;
  logic [7:0]  t_len, rbeat, wbeat;
  int          starve;
  logic        last_gi;

  logic e_gi, e_gd, ph_a, ph_r, ph_w, ph_b, e_irv, e_drv, e_mwv, e_dwr;

  always_comb begin
    e_gi  = !t_active && i_req_valid && !i_clr && (!d_req_valid || starve == LIMIT);
    e_gd  = !t_active && !e_gi && d_req_valid;
    ph_a  = t_active && !t_adone;
    ph_r  = t_active && t_adone && !t_write;
    ph_w  = t_active && t_adone && t_write && !t_ddone;
    ph_b  = t_active && t_write && t_ddone;
    e_irv = ph_r && !t_own_d && !t_drop && m_rvalid;
    e_drv = ph_r && t_own_d && m_rvalid;
    e_mwv = ph_w && d_wvalid;
    e_dwr = ph_w && m_wready;
  end

  always @(posedge clk) begin
    last_gi <= e_gi && !rst;
    if (rst) begin
      t_active <= 1'b0; t_own_d <= 1'b0; t_write <= 1'b0; t_adone <= 1'b0; t_ddone <= 1'b0;
      t_drop <= 1'b0; t_addr <= 32'd0; t_len <= 8'd0; rbeat <= 8'd0; wbeat <= 8'd0; starve <= 0;
    end else begin
      if (e_gi || i_clr || !i_req_valid) starve <= 0;
      else if (starve < LIMIT) starve <= starve + 1;
      if (!t_active) begin
        t_drop <= 1'b0;
        if (e_gi || e_gd) begin
          t_active <= 1'b1; t_own_d <= e_gd; t_write <= e_gd && d_req_write;
          t_addr <= e_gd ? d_req_addr : i_req_addr;
          t_len  <= e_gd ? d_req_len : i_req_len;
          t_adone <= 1'b0; t_ddone <= 1'b0; rbeat <= 8'd0; wbeat <= 8'd0;
        end
      end else begin
        if (ph_a && m_aready) t_adone <= 1'b1;
        if (ph_r && m_rvalid) rbeat <= rbeat + 8'd1;
        if (ph_w && d_wvalid && m_wready) begin
          wbeat <= wbeat + 8'd1;
          if (d_wlast) t_ddone <= 1'b1;
        end
        if ((ph_r && m_rvalid && m_rlast) || (ph_b && m_bvalid)) begin
          t_active <= 1'b0; t_drop <= 1'b0;
        end else if (!t_own_d && i_clr) begin
          t_drop <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("i_req_ready", 32'(i_req_ready), 32'(e_gi));
      chk("d_req_ready", 32'(d_req_ready), 32'(e_gd));
      chk("m_avalid", 32'(m_avalid), 32'(ph_a));
      if (ph_a) begin
        chk("m_aaddr", m_aaddr, t_addr);
        chk("m_alen", 32'(m_alen), 32'(t_len));
        chk("m_awrite", 32'(m_awrite), 32'(t_write));
      end
      chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
      chk("i_rlast", 32'(i_rlast), 32'(e_irv && m_rlast));
      if (e_irv) chk("i_rdata", i_rdata, m_rdata);
      chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
      chk("d_rlast", 32'(d_rlast), 32'(e_drv && m_rlast));
      if (e_drv) chk("d_rdata", d_rdata, m_rdata);
      chk("m_wvalid", 32'(m_wvalid), 32'(e_mwv));
      chk("d_wready", 32'(d_wready), 32'(e_dwr));
      if (e_mwv) begin
        chk("m_wdata", m_wdata, d_wdata);
        chk("m_wstrb", 32'(m_wstrb), 32'(d_wstrb));
        chk("m_wlast", 32'(m_wlast), 32'(d_wlast));
      end
      chk("bus_busy_o", 32'(bus_busy_o), 32'(t_active));
    end
  end

  task automatic clr_in();
    i_req_valid = 0; i_req_addr = 0; i_req_len = 0; i_clr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_len = 0; d_req_write = 0;
    d_wvalid = 0; d_wdata = 0; d_wstrb = 0; d_wlast = 0;
    m_aready = 0; m_wready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0; m_bvalid = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'({i_req_ready, d_req_ready}), 0);
    chk({tag, "_valids"}, 32'({m_avalid, m_wvalid, d_wready, i_rvalid, d_rvalid}), 0);
    chk({tag, "_lasts"}, 32'({i_rlast, d_rlast, m_wlast}), 0);
    chk({tag, "_busy"}, 32'(bus_busy_o), 0);
    chk({tag, "_aaddr"}, m_aaddr, 0);
    chk({tag, "_alen"}, 32'(m_alen), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      i_req_valid = 0; d_req_valid = 0; i_clr = 0;
      m_aready = 1; m_rvalid = ph_r; m_rlast = ph_r; m_rdata = $urandom;
      m_wready = 1; d_wvalid = ph_w; d_wlast = ph_w && (wbeat == t_len); m_bvalid = ph_b;
      if (!t_active) break;
    end
    #1 chk("drain_idle", 32'(bus_busy_o), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int contended;
    bit got;
    rst = 1; clr_in();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); rst = 0;

    // Single I read, 4 beats
    @(negedge clk); i_req_valid = 1; i_req_addr = 32'h1C00_0000; i_req_len = 8'd3;
    #1 chk("single_grant", 32'(i_req_ready), 1);
    @(negedge clk); i_req_valid = 0; m_aready = 1;
    #1 chk("single_avalid", 32'(m_avalid), 1);
    chk("single_aaddr", m_aaddr, 32'h1C00_0000);
    chk("single_alen", 32'(m_alen), 3);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); m_aready = 0; m_rvalid = 1; m_rdata = 32'hA + 32'(b); m_rlast = (b == 3);
      #1 chk("single_rdata", i_rdata, 32'hA + 32'(b));
      chk("single_rlast", 32'(i_rlast), 32'(b == 3));
    end
    @(negedge clk); m_rvalid = 0; m_rlast = 0;
    #1 chk("single_done", 32'(bus_busy_o), 0);

    // Simultaneous requests: D read first, I right after D's last beat
    @(negedge clk); i_req_valid = 1; i_req_addr = 32'h0000_1000; i_req_len = 0;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h0000_2000; d_req_len = 1;
    #1 chk("simul_d_first", 32'({d_req_ready, i_req_ready}), 32'b10);
    @(negedge clk); d_req_valid = 0; m_aready = 1;
    @(negedge clk); m_aready = 0; m_rvalid = 1; m_rlast = 0; m_rdata = 32'h11;
    @(negedge clk); m_rlast = 1; m_rdata = 32'h22;
    #1 chk("simul_d_rlast", 32'(d_rlast), 1);
    @(negedge clk); m_rvalid = 0; m_rlast = 0;
    #1 chk("simul_i_next", 32'(i_req_ready), 1);
    drain();

    // Starvation: D hammers single-beat reads, I must still win
    contended = 0; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      i_req_valid = 1; i_req_len = 0; d_req_valid = 1; d_req_write = 0; d_req_len = 0;
      m_aready = 1; m_rvalid = ph_r; m_rlast = ph_r;
      #1;
      if (!t_active) contended++;
      if (i_req_ready) begin got = 1; break; end
    end
    chk("starve_grant", 32'(got), 1);
    chk("starve_within_4", 32'(contended <= 4), 1);
    drain();

    // Write burst len 1 with m_wready 1,0,1
    @(negedge clk); d_req_valid = 1; d_req_write = 1; d_req_len = 1; d_req_addr = 32'h8000_0040;
    #1 chk("wr_grant", 32'(d_req_ready), 1);
    @(negedge clk); d_req_valid = 0; m_aready = 1;
    #1 chk("wr_awrite", 32'({m_avalid, m_awrite}), 32'b11);
    @(negedge clk); m_aready = 0; d_wvalid = 1; d_wdata = 32'h1111_0000; d_wstrb = 4'hF; d_wlast = 0; m_wready = 1;
    #1 chk("wr_beat0", m_wdata, 32'h1111_0000);
    @(negedge clk); d_wdata = 32'h2222_0001; d_wlast = 1; m_wready = 0;
    #1 chk("wr_stall", 32'(d_wready), 0);
    @(negedge clk); m_wready = 1;
    #1 chk("wr_beat1_last", 32'({m_wvalid, m_wlast}), 32'b11);
    @(negedge clk); d_wvalid = 0; d_wlast = 0; m_wready = 0;
    #1 chk("wr_resp_wait", 32'({bus_busy_o, m_wvalid}), 32'b10);
    @(negedge clk); m_bvalid = 1;
    @(negedge clk); m_bvalid = 0;
    #1 chk("wr_done", 32'(bus_busy_o), 0);

    // Cancelled I read
    @(negedge clk); i_req_valid = 1; i_req_len = 3; i_req_addr = 32'h1C00_0100;
    #1 chk("clr_grant", 32'(i_req_ready), 1);
    @(negedge clk); i_req_valid = 0; m_aready = 1;
    @(negedge clk); m_aready = 0; m_rvalid = 1; m_rlast = 0; m_rdata = 32'h5;
    #1 chk("clr_beat1", 32'(i_rvalid), 1);
    @(negedge clk); m_rvalid = 0; i_clr = 1;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk); i_clr = 0; m_rvalid = 1; m_rlast = (b == 3); m_rdata = 32'(b);
      #1 chk("clr_dropped", 32'({i_rvalid, i_rlast}), 0);
    end
    @(negedge clk); m_rvalid = 0; m_rlast = 0; d_req_valid = 1; d_req_write = 0; d_req_len = 0;
    #1 chk("clr_then_d", 32'({bus_busy_o, d_req_ready}), 32'b01);
    drain();

    // i_clr in the would-be grant cycle
    @(negedge clk); i_req_valid = 1; i_clr = 1;
    #1 chk("clr_no_grant", 32'(i_req_ready), 0);
    @(negedge clk); d_req_valid = 1; d_req_write = 0; d_req_len = 0;
    #1 chk("clr_d_wins", 32'({d_req_ready, i_req_ready}), 32'b10);
    drain();

    // Reset in the middle of a D write; I keeps starving meanwhile
    @(negedge clk); i_req_valid = 1; d_req_valid = 1; d_req_write = 1; d_req_len = 3; d_req_addr = 32'h4000_0000;
    @(negedge clk); d_req_valid = 0; m_aready = 1;
    @(negedge clk); m_aready = 0; d_wvalid = 1; d_wdata = 32'hDEAD_0000; d_wstrb = 4'h3; m_wready = 1;
    #1 chk("rst_in_wdata", 32'(m_wvalid), 1);
    @(negedge clk); rst = 1; d_req_valid = 1;
    @(posedge clk); #1 chk_all_zero("midrst");
    @(negedge clk); rst = 0; clr_in(); i_req_valid = 1; d_req_valid = 1; d_req_len = 0;
    #1 chk("post_rst_d_wins", 32'({d_req_ready, i_req_ready}), 32'b10);
    drain();

    // Randomized traffic
    clr_in();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!i_req_valid || last_gi) begin
        i_req_valid = ($urandom_range(0, 2) == 0);
        i_req_addr = $urandom; i_req_len = 8'($urandom_range(0, 3));
      end
      if (!d_req_valid || d_req_ready === 1'b1 && 1'b0) d_req_valid = ($urandom_range(0, 2) == 0);
      if (!t_active || t_own_d) begin
        d_req_addr = $urandom; d_req_len = 8'($urandom_range(0, 3)); d_req_write = 1'($urandom_range(0, 1));
      end
      i_clr = ($urandom_range(0, 15) == 0);
      m_aready = 1'($urandom_range(0, 1));
      m_rvalid = ph_r && ($urandom_range(0, 1) == 1);
      m_rlast = m_rvalid && (rbeat == t_len);
      m_rdata = $urandom;
      d_wvalid = ph_w && ($urandom_range(0, 1) == 1);
      d_wlast = ph_w && (wbeat == t_len);
      d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      m_wready = 1'($urandom_range(0, 1));
      m_bvalid = ph_b && ($urandom_range(0, 2) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
